sb_dsp: RTL and testbench
=========================

SB_DSP -- requirements
Module: sb_dsp

Interface
REQ-001 Parameter: CLK_PER_US, default 50, clk cycles per microsecond.
REQ-002 Parameter: BASE, default 10'h220, DSP base I/O address.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 addr  in  10  ISA address, stable while any strobe is high.
REQ-006 wdata  in  8  ISA data, sampled on io_wr_stb.
REQ-007 io_wr_stb  in  1  one-cycle pulse at end of an IOW cycle, already synchronised.
REQ-008 io_rd_stb  in  1  one-cycle pulse at start of an IOR cycle.
REQ-009 io_rd_done  in  1  one-cycle pulse at end of an IOR cycle.
REQ-010 dack_n  in  1  DMA channel 1 acknowledge, active-low, synchronised.
REQ-011 rdata  out  8  read data for claimed ports.
REQ-012 rdata_oe  out  1  high while sb_dsp drives the ISA bus.
REQ-013 drq  out  1  DMA channel 1 request, active-high.
REQ-014 irq  out  1  interrupt level, active-high.
REQ-015 pcm  out  8  unsigned 8-bit sample, 8'h80 = silence.
REQ-016 pcm_valid  out  1  one-cycle pulse when pcm updates.

Function
REQ-017 Port writes SHALL decode only when dack_n=1; io_wr_stb with dack_n=0 SHALL be a DMA byte, never a port write.
REQ-018 BASE+6 write: value 1 then 0 SHALL run DSP reset: abort DMA, drq=0, irq=0, flush read queue, TC=8'hA6, speaker off, then push 8'hAA.
REQ-019 Read queue: 2 entries; push onto full queue SHALL drop the byte; read of empty queue SHALL return the last byte read.
REQ-020 BASE+A read SHALL pop the read queue; BASE+E read SHALL return {queue_not_empty,7'h7F} and clear irq; BASE+C read SHALL return 8'h00 (always ready).
REQ-021 rdata SHALL be registered on io_rd_stb (valid next cycle); rdata_oe SHALL assert the same cycle and hold until io_rd_done; unclaimed addresses SHALL leave rdata_oe=0.
REQ-022 Command FSM states: IDLE, TC_ARG, LEN_LO, LEN_HI; only BASE+C writes advance it.
REQ-023 IDLE: 8'h40->TC_ARG; 8'h14->LEN_LO; 8'hD0 pause DMA; 8'hD4 resume DMA; 8'hD1 speaker on; 8'hD3 speaker off; 8'hE1 push 8'h02 then 8'h01; other codes ignored, stay IDLE.
REQ-024 TC_ARG: byte->TC, ->IDLE. LEN_LO: byte->lo, ->LEN_HI. LEN_HI: remaining={byte,lo}+1 (17-bit, 1..65536), start DMA, ->IDLE.
REQ-025 DMA states: D_IDLE, D_REQ, D_WAIT; start SHALL enter D_REQ next cycle, overriding any active transfer.
REQ-026 D_REQ: drq=1; on dack_n=0 and io_wr_stb: capture wdata, drq=0 same edge, remaining-1, pcm_valid pulse next cycle.
REQ-027 After capture: remaining=0 -> D_IDLE, irq=1; else D_WAIT loads period=CLK_PER_US*(256-TC) cycles, then -> D_REQ.
REQ-028 Period counter SHALL be 24 bits; TC=255 gives CLK_PER_US cycles; TC change SHALL apply at next load.
REQ-029 Pause (D0) SHALL hold state and counter with drq=0; resume (D4) SHALL continue; D0 with no DMA SHALL be a no-op.
REQ-030 pcm SHALL equal the captured byte when speaker on, else 8'h80; pcm_valid SHALL pulse on every capture regardless.
REQ-031 irq set and BASE+E read in the same cycle: irq SHALL end set.

Reset
REQ-032 rst SHALL force: FSMs to IDLE/D_IDLE, drq=0, irq=0, rdata=0, rdata_oe=0, pcm=8'h80, pcm_valid=0, TC=8'hA6, speaker off, queue empty, remaining=0.
REQ-033 rst mid-transfer SHALL drop drq the next edge; no capture, pcm_valid or irq SHALL follow.

Structure
REQ-034 Package sb_pkg SHALL hold port offsets, command codes, FSM state enums and the 8'hA6/8'hAA/8'h80 constants.
REQ-035 One sub-module, sb_rate_timer: 24-bit loadable down-counter with pause and one-cycle expiry pulse.

Verification
REQ-036 Write 1,0 to 226h; read 22Eh -> 8'hFF; read 22Ah -> 8'hAA; read 22Eh -> 8'h7F.
REQ-037 Cmds 40h,FFh,14h,02h,00h; serve 3 DACK bytes 10h,20h,30h -> drq pulses 3x, 50 cycles apart, pcm=80h (speaker off), 3 pcm_valid, irq=1 after third.
REQ-038 D1h, then 14h,00h,00h; DACK byte 5Ah -> pcm=5Ah, irq=1; read 22Eh -> irq=0.
REQ-039 Start 14h,FFh,FFh; after 2 bytes issue D0h -> drq stays 0 for 10000 cycles; D4h -> drq returns, remaining=65534.
REQ-040 E1h then E1h without reads -> reads 22Ah give 02h,01h, then 01h again (second E1h dropped).
REQ-041 rst asserted while drq=1 -> drq=0 next cycle, pcm=80h, no irq over 1000 cycles.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared definitions for the SB DSP block.
// Holds the port offsets, command codes, FSM state enums and the reset/ack/silence
// constants, plus the helper that converts a time constant into a period.
package sb_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned REM_W  = 17;

    // Offsets of the DSP ports from the base I/O address
    localparam logic [ADDR_W-1:0] OFF_RESET  = 10'h006;
    localparam logic [ADDR_W-1:0] OFF_READ   = 10'h00A;
    localparam logic [ADDR_W-1:0] OFF_WRITE  = 10'h00C;
    localparam logic [ADDR_W-1:0] OFF_STATUS = 10'h00E;

    // DSP command codes
    localparam logic [DATA_W-1:0] CMD_SET_TC  = 8'h40;
    localparam logic [DATA_W-1:0] CMD_DMA8    = 8'h14;
    localparam logic [DATA_W-1:0] CMD_PAUSE   = 8'hD0;
    localparam logic [DATA_W-1:0] CMD_RESUME  = 8'hD4;
    localparam logic [DATA_W-1:0] CMD_SPK_ON  = 8'hD1;
    localparam logic [DATA_W-1:0] CMD_SPK_OFF = 8'hD3;
    localparam logic [DATA_W-1:0] CMD_VERSION = 8'hE1;

    localparam logic [DATA_W-1:0] TC_DEFAULT  = 8'hA6;
    localparam logic [DATA_W-1:0] RESET_ACK   = 8'hAA;
    localparam logic [DATA_W-1:0] PCM_SILENCE = 8'h80;
    localparam logic [DATA_W-1:0] VER_MAJOR   = 8'h02;
    localparam logic [DATA_W-1:0] VER_MINOR   = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TC_ARG = 2'd1,
        LEN_LO = 2'd2,
        LEN_HI = 2'd3
    } cmd_state_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_REQ  = 2'd1,
        D_WAIT = 2'd2
    } dma_state_e;

    // Sample period in clk cycles: clk_per_us * (256 - tc)
    function automatic logic [CNT_W-1:0] dma_period(input int unsigned clk_per_us,
                                                    input logic [DATA_W-1:0] tc);
        return CNT_W'(clk_per_us) * (CNT_W'(256) - CNT_W'(tc));
    endfunction

endpackage

// File: rtl/sb_rate_timer.sv
// Loadable 24-bit down-counter that paces DMA requests.
// Ports: clk, rst (sync, active-high), load/load_val (reload the count),
// pause (freeze the count), expire_c (one-cycle pulse on the last count).
module sb_rate_timer
    import sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             pause,
    output logic             expire_c
);

    logic [CNT_W-1:0] count;

    // Count down to zero, frozen while paused
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!pause && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // Fires in the cycle whose edge takes the count from 1 to 0
    assign expire_c = !pause && !load && (count == CNT_W'(1));

endmodule

// File: rtl/sb_dsp.sv
// 8-bit single-cycle DMA playback core of an SB-compatible DSP.
// Ports: clk, rst (sync, active-high); ISA side addr/wdata/io_wr_stb/io_rd_stb/
// io_rd_done -> rdata/rdata_oe; DMA channel 1 dack_n -> drq; irq level;
// pcm sample with pcm_valid pulse on every captured DMA byte.
module sb_dsp
    import sb_pkg::*;
#(
    parameter int unsigned       CLK_PER_US = 50,
    parameter logic [ADDR_W-1:0] BASE       = 10'h220
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              io_wr_stb,
    input  logic              io_rd_stb,
    input  logic              io_rd_done,
    input  logic              dack_n,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    output logic              drq,
    output logic              irq,
    output logic [DATA_W-1:0] pcm,
    output logic              pcm_valid
);

    localparam logic [ADDR_W-1:0] A_RESET  = BASE + OFF_RESET;
    localparam logic [ADDR_W-1:0] A_READ   = BASE + OFF_READ;
    localparam logic [ADDR_W-1:0] A_WRITE  = BASE + OFF_WRITE;
    localparam logic [ADDR_W-1:0] A_STATUS = BASE + OFF_STATUS;

    cmd_state_e        cmd_state;
    dma_state_e        dma_state;
    logic [DATA_W-1:0] tc;
    logic [DATA_W-1:0] len_lo;
    logic [REM_W-1:0]  remaining;
    logic              spk;
    logic              paused;
    logic              rst_armed;

    // Two-entry read queue; last_rd is replayed when the queue is empty
    logic [DATA_W-1:0] q0, q1, last_rd;
    logic [1:0]        q_cnt;
    logic [DATA_W-1:0] q0_n, q1_n, last_n;
    logic [1:0]        cnt_n;

    logic port_wr, dma_wr, wr_reset, wr_cmd, cmd_idle;
    logic rd_data, rd_status, rd_wbuf, rd_claim;
    logic dsp_reset, capture, start, version, last_byte, irq_set;
    logic pause_cmd, resume_cmd;
    logic [DATA_W-1:0] rd_mux;
    logic [CNT_W-1:0]  period;
    logic              timer_expire_c;

    // A write strobe while DACK is low is a DMA byte, never a port access
    assign port_wr   = io_wr_stb && dack_n;
    assign dma_wr    = io_wr_stb && !dack_n;
    assign wr_reset  = port_wr && (addr == A_RESET);
    assign wr_cmd    = port_wr && (addr == A_WRITE);
    assign cmd_idle  = wr_cmd && (cmd_state == IDLE);
    assign rd_data   = io_rd_stb && (addr == A_READ);
    assign rd_status = io_rd_stb && (addr == A_STATUS);
    assign rd_wbuf   = io_rd_stb && (addr == A_WRITE);
    assign rd_claim  = rd_data || rd_status || rd_wbuf;

    assign dsp_reset  = wr_reset && !wdata[0] && rst_armed;
    assign capture    = (dma_state == D_REQ) && !paused && dma_wr;
    assign start      = wr_cmd && (cmd_state == LEN_HI);
    assign version    = cmd_idle && (wdata == CMD_VERSION);
    assign pause_cmd  = cmd_idle && (wdata == CMD_PAUSE) && (dma_state != D_IDLE);
    assign resume_cmd = cmd_idle && (wdata == CMD_RESUME);
    assign last_byte  = (remaining == REM_W'(1));
    assign irq_set    = capture && last_byte;
    assign period     = dma_period(CLK_PER_US, tc);

    // Read-back mux, sampled into rdata on the read strobe
    always_comb begin
        rd_mux = 8'h00;
        if (rd_data) begin
            rd_mux = (q_cnt != 2'd0) ? q0 : last_rd;
        end else if (rd_status) begin
            rd_mux = {q_cnt != 2'd0, 7'h7F};
        end
    end

    // Queue next state: flush, then pop, then pushes (dropped when full)
    always_comb begin
        q0_n   = q0;
        q1_n   = q1;
        cnt_n  = q_cnt;
        last_n = last_rd;
        if (dsp_reset) begin
            cnt_n = 2'd0;
        end
        if (rd_data && cnt_n != 2'd0) begin
            last_n = q0_n;
            q0_n   = q1_n;
            cnt_n  = cnt_n - 2'd1;
        end
        if (dsp_reset || version) begin
            if (cnt_n == 2'd0) begin
                q0_n  = dsp_reset ? RESET_ACK : VER_MAJOR;
                cnt_n = 2'd1;
            end else if (cnt_n == 2'd1) begin
                q1_n  = dsp_reset ? RESET_ACK : VER_MAJOR;
                cnt_n = 2'd2;
            end
        end
        if (version) begin
            if (cnt_n == 2'd0) begin
                q0_n  = VER_MINOR;
                cnt_n = 2'd1;
            end else if (cnt_n == 2'd1) begin
                q1_n  = VER_MINOR;
                cnt_n = 2'd2;
            end
        end
    end

    // Command parser, DMA sequencer, bus read side and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_state <= IDLE;
            dma_state <= D_IDLE;
            tc        <= TC_DEFAULT;
            len_lo    <= '0;
            remaining <= '0;
            spk       <= 1'b0;
            paused    <= 1'b0;
            rst_armed <= 1'b0;
            irq       <= 1'b0;
            drq       <= 1'b0;
            pcm       <= PCM_SILENCE;
            pcm_valid <= 1'b0;
            rdata     <= '0;
            rdata_oe  <= 1'b0;
            q0        <= '0;
            q1        <= '0;
            q_cnt     <= 2'd0;
            last_rd   <= '0;
        end else begin
            pcm_valid <= 1'b0;
            q0        <= q0_n;
            q1        <= q1_n;
            q_cnt     <= cnt_n;
            last_rd   <= last_n;

            if (wr_reset) begin
                rst_armed <= wdata[0];
            end

            if (io_rd_done) begin
                rdata_oe <= 1'b0;
            end
            if (rd_claim) begin
                rdata_oe <= 1'b1;
                rdata    <= rd_mux;
            end

            // A new interrupt beats a simultaneous status-read acknowledge
            if (irq_set) begin
                irq <= 1'b1;
            end else if (rd_status || dsp_reset) begin
                irq <= 1'b0;
            end

            if (capture) begin
                pcm       <= spk ? wdata : PCM_SILENCE;
                pcm_valid <= 1'b1;
            end

            if (dsp_reset) begin
                cmd_state <= IDLE;
                tc        <= TC_DEFAULT;
                spk       <= 1'b0;
            end else if (wr_cmd) begin
                case (cmd_state)
                    IDLE: begin
                        case (wdata)
                            CMD_SET_TC:  cmd_state <= TC_ARG;
                            CMD_DMA8:    cmd_state <= LEN_LO;
                            CMD_SPK_ON:  spk       <= 1'b1;
                            CMD_SPK_OFF: spk       <= 1'b0;
                            default: ;
                        endcase
                    end
                    TC_ARG: begin
                        tc        <= wdata;
                        cmd_state <= IDLE;
                    end
                    LEN_LO: begin
                        len_lo    <= wdata;
                        cmd_state <= LEN_HI;
                    end
                    LEN_HI:  cmd_state <= IDLE;
                    default: cmd_state <= IDLE;
                endcase
            end

            if (dsp_reset) begin
                dma_state <= D_IDLE;
                drq       <= 1'b0;
                paused    <= 1'b0;
                remaining <= '0;
            end else if (start) begin
                // Length byte pair encodes count-1, so 0000h means one byte
                dma_state <= D_REQ;
                drq       <= 1'b1;
                paused    <= 1'b0;
                remaining <= REM_W'({wdata, len_lo}) + REM_W'(1);
            end else begin
                case (dma_state)
                    D_REQ: begin
                        if (capture) begin
                            drq       <= 1'b0;
                            remaining <= remaining - REM_W'(1);
                            dma_state <= last_byte ? D_IDLE : D_WAIT;
                        end
                    end
                    D_WAIT: begin
                        if (timer_expire_c) begin
                            dma_state <= D_REQ;
                            drq       <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                // Pause/resume placed last so they win over a same-cycle expiry
                if (pause_cmd) begin
                    paused <= 1'b1;
                    drq    <= 1'b0;
                end else if (resume_cmd) begin
                    paused <= 1'b0;
                    drq    <= (dma_state == D_REQ);
                end
            end
        end
    end

    sb_rate_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (capture),
        .load_val (period),
        .pause    (paused),
        .expire_c (timer_expire_c)
    );

endmodule

// File: tb/tb_sb_dsp.sv
// Bench for sb_dsp: directed ISA/DMA sequences, an event-level reference model
// compared every cycle, and literal expectations at the key points.
module tb_sb_dsp;

    localparam int unsigned CPU = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic       io_wr_stb, io_rd_stb, io_rd_done, dack_n;
    logic [7:0] rdata;
    logic       rdata_oe, drq, irq;
    logic [7:0] pcm;
    logic       pcm_valid;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sb_dsp #(.CLK_PER_US(CPU), .BASE(10'h220)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .io_wr_stb  (io_wr_stb),
        .io_rd_stb  (io_rd_stb),
        .io_rd_done (io_rd_done),
        .dack_n     (dack_n),
        .rdata      (rdata),
        .rdata_oe   (rdata_oe),
        .drq        (drq),
        .irq        (irq),
        .pcm        (pcm),
        .pcm_valid  (pcm_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_xfer;      // 0 none, 1 requesting, 2 waiting for period
    int         m_wait;
    bit         m_paused;
    int         m_rem;
    int         m_tc;
    bit         m_spk;
    bit         m_armed;
    int         m_cmd;       // 0 idle, 1 tc arg, 2 len lo, 3 len hi
    logic [7:0] m_lo;
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    bit         m_irq;
    logic [7:0] m_pcm;
    bit         m_pv;
    logic [7:0] m_rdata;
    bit         m_oe;
    bit         m_irq_set, m_irq_clr;

    task automatic m_dsp_reset();
        m_xfer = 0; m_paused = 0; m_rem = 0; m_irq = 0; m_tc = 'hA6; m_spk = 0; m_cmd = 0;
        m_q.delete();
        m_q.push_back(8'hAA);
    endtask

    task automatic m_command(input logic [7:0] b);
        case (m_cmd)
            0: begin
                case (b)
                    8'h40: m_cmd = 1;
                    8'h14: m_cmd = 2;
                    8'hD0: if (m_xfer != 0) m_paused = 1;
                    8'hD4: m_paused = 0;
                    8'hD1: m_spk = 1;
                    8'hD3: m_spk = 0;
                    8'hE1: begin
                        if (m_q.size() < 2) m_q.push_back(8'h02);
                        if (m_q.size() < 2) m_q.push_back(8'h01);
                    end
                    default: ;
                endcase
            end
            1: begin m_tc = int'(b); m_cmd = 0; end
            2: begin m_lo = b; m_cmd = 3; end
            default: begin
                m_rem = int'(b) * 256 + int'(m_lo) + 1;
                m_xfer = 1; m_paused = 0; m_cmd = 0;
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_xfer = 0; m_wait = 0; m_paused = 0; m_rem = 0; m_tc = 'hA6; m_spk = 0;
            m_armed = 0; m_cmd = 0; m_lo = 0; m_q.delete(); m_last = 0; m_irq = 0;
            m_pcm = 8'h80; m_pv = 0; m_rdata = 0; m_oe = 0;
        end else begin
            m_pv = 0; m_irq_set = 0; m_irq_clr = 0;
            if (io_rd_done) m_oe = 0;
            if (io_rd_stb) begin
                case (addr)
                    10'h22A: begin
                        m_oe = 1;
                        if (m_q.size() > 0) m_last = m_q.pop_front();
                        m_rdata = m_last;
                    end
                    10'h22E: begin m_oe = 1; m_rdata = {m_q.size() != 0, 7'h7F}; m_irq_clr = 1; end
                    10'h22C: begin m_oe = 1; m_rdata = 8'h00; end
                    default: ;
                endcase
            end
            if (m_xfer == 1 && !m_paused && io_wr_stb && !dack_n) begin
                m_pv = 1;
                m_pcm = m_spk ? wdata : 8'h80;
                m_rem--;
                if (m_rem == 0) begin m_xfer = 0; m_irq_set = 1; end
                else begin m_xfer = 2; m_wait = int'(CPU) * (256 - m_tc); end
            end else if (m_xfer == 2 && !m_paused) begin
                m_wait--;
                if (m_wait == 0) m_xfer = 1;
            end
            if (io_wr_stb && dack_n) begin
                if (addr == 10'h226) begin
                    if (!wdata[0] && m_armed) m_dsp_reset();
                    m_armed = wdata[0];
                end else if (addr == 10'h22C) begin
                    m_command(wdata);
                end
            end
            if (m_irq_set) m_irq = 1;
            else if (m_irq_clr) m_irq = 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_drq", drq, (m_xfer == 1 && !m_paused));
            chk("cyc_irq", irq, m_irq);
            chk("cyc_pcm", pcm, m_pcm);
            chk("cyc_pcm_valid", pcm_valid, m_pv);
            chk("cyc_rdata_oe", rdata_oe, m_oe);
            if (m_oe) chk("cyc_rdata", rdata, m_rdata);
        end
    end

    int pv_cnt = 0;
    int rise_cnt = 0;
    bit drq_q = 0;
    always @(negedge clk) begin
        if (pcm_valid) pv_cnt++;
        if (drq && !drq_q) rise_cnt++;
        drq_q = drq;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; io_wr_stb = 1;
        @(negedge clk);
        io_wr_stb = 0;
    endtask

    task automatic rd(input logic [9:0] a, input bit claimed, input logic [7:0] exp, input string name);
        @(negedge clk);
        addr = a; io_rd_stb = 1;
        @(negedge clk);
        io_rd_stb = 0;
        chk({name, "_oe"}, rdata_oe, claimed);
        if (claimed) chk(name, rdata, exp);
        io_rd_done = 1;
        @(negedge clk);
        io_rd_done = 0;
        chk({name, "_oe_off"}, rdata_oe, 0);
    endtask

    task automatic serve(input logic [7:0] b, input string name);
        int n = 0;
        while (!drq && n < 2000) begin @(negedge clk); n++; end
        chk({name, "_drq_up"}, drq, 1);
        if (drq) begin
            dack_n = 0; wdata = b; io_wr_stb = 1;
            @(negedge clk);
            io_wr_stb = 0; dack_n = 1;
        end
    endtask

    task automatic low_time(output int low);
        low = 0;
        while (!drq && low < 5000) begin low++; @(negedge clk); end
    endtask

    int low, pv0, rise0, hits;

    initial begin
        rst = 1; addr = 0; wdata = 0; io_wr_stb = 0; io_rd_stb = 0; io_rd_done = 0; dack_n = 1;
        repeat (3) @(negedge clk);
        chk("rst_drq", drq, 0);
        chk("rst_irq", irq, 0);
        chk("rst_pcm", pcm, 8'h80);
        chk("rst_pcm_valid", pcm_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rdata_oe", rdata_oe, 0);
        cmp_en = 1;
        rst = 0;

        // DSP reset handshake and queue readback
        wr(10'h226, 8'h01);
        wr(10'h226, 8'h00);
        rd(10'h22E, 1, 8'hFF, "stat_after_reset");
        rd(10'h22A, 1, 8'hAA, "reset_ack");
        rd(10'h22E, 1, 8'h7F, "stat_empty");
        rd(10'h22B, 0, 8'h00, "unclaimed");
        rd(10'h22C, 1, 8'h00, "wbuf_ready");

        // Three-byte transfer at TC=FF: 50-cycle spacing, speaker off
        pv0 = pv_cnt; rise0 = rise_cnt;
        wr(10'h22C, 8'h40); wr(10'h22C, 8'hFF);
        wr(10'h22C, 8'h14); wr(10'h22C, 8'h02); wr(10'h22C, 8'h00);
        serve(8'h10, "b1");
        chk("b1_pcm", pcm, 8'h80);
        low_time(low);
        chk("gap1", low, 50);
        serve(8'h20, "b2");
        low_time(low);
        chk("gap2", low, 50);
        serve(8'h30, "b3");
        chk("b3_irq", irq, 1);
        chk("b3_drq", drq, 0);
        chk("b3_pcm", pcm, 8'h80);
        repeat (60) @(negedge clk);
        chk("xfer3_pv", pv_cnt - pv0, 3);
        chk("xfer3_drq_pulses", rise_cnt - rise0, 3);

        // Single byte with speaker on, irq acknowledged by status read
        rd(10'h22E, 1, 8'h7F, "ack1");
        chk("ack1_irq", irq, 0);
        wr(10'h22C, 8'hD1);
        wr(10'h22C, 8'h14); wr(10'h22C, 8'h00); wr(10'h22C, 8'h00);
        serve(8'h5A, "one");
        chk("one_pcm", pcm, 8'h5A);
        chk("one_irq", irq, 1);
        rd(10'h22E, 1, 8'h7F, "ack2");
        chk("ack2_irq", irq, 0);

        // Version command twice: second is dropped on the full queue
        wr(10'h22C, 8'hE1);
        wr(10'h22C, 8'hE1);
        rd(10'h22A, 1, 8'h02, "ver_major");
        rd(10'h22A, 1, 8'h01, "ver_minor");
        rd(10'h22A, 1, 8'h01, "ver_replay");

        // 65536-byte transfer paused after two bytes
        wr(10'h22C, 8'h14); wr(10'h22C, 8'hFF); wr(10'h22C, 8'hFF);
        serve(8'h01, "p1");
        serve(8'h02, "p2");
        wr(10'h22C, 8'hD0);
        hits = 0;
        repeat (10000) begin @(negedge clk); if (drq) hits++; end
        chk("pause_drq_hits", hits, 0);
        wr(10'h22C, 8'hD4);
        low_time(low);
        chk("resume_drq", drq, 1);
        chk("resume_remaining", dut.remaining, 65534);

        // Hardware reset while drq is high
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("hwrst_drq", drq, 0);
        chk("hwrst_pcm", pcm, 8'h80);
        pv0 = pv_cnt; hits = 0;
        repeat (1000) begin @(negedge clk); if (irq || drq) hits++; end
        chk("hwrst_quiet", hits, 0);
        chk("hwrst_no_pv", pv_cnt - pv0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
